// File: rtl/core_idu_pkg.sv
// Shared types and helpers for the IDU register file and scoreboard.
package core_idu_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_DEPTH = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  // Returns 1 when the address names a register that has real storage.
  // Register 0 is hardwired to zero when zero_reg is set.
  function automatic logic addr_is_real(input logic [31:0] addr, input logic zero_reg);
    return !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/idu_regfile_sb_rdport.sv
// Single combinational read port: storage lookup, zero-register masking,
// same-cycle write bypass and busy masking.
module idu_regfile_sb_rdport
  import core_idu_pkg::*;
#(
  parameter int unsigned XLEN     = DEF_XLEN,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic             run,
  input  logic [AW-1:0]    rs_addr,
  input  logic [XLEN-1:0]  mem [DEPTH],
  input  logic [DEPTH-1:0] busy_vec,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [XLEN-1:0]  wr_data,
  output logic [XLEN-1:0]  rs_data,
  output logic             rs_busy
);

  logic addr_real;
  logic byp_hit;

  // Read data and busy, with bypass and CLEAR-time masking.
  always_comb begin
    rs_data   = '0;
    rs_busy   = 1'b0;
    addr_real = addr_is_real(32'(rs_addr), ZERO_REG != 0);
    byp_hit   = (BYPASS != 0) && wr_en && (wr_addr == rs_addr) && addr_real;
    if (run && addr_real) begin
      rs_data = byp_hit ? wr_data : mem[rs_addr];
      rs_busy = busy_vec[rs_addr] && !byp_hit;
    end
  end

endmodule

// File: rtl/idu_regfile_sb.sv
// Integer register file with per-register busy scoreboard and a
// post-reset clear engine that zeroes the storage before use.
module idu_regfile_sb
  import core_idu_pkg::*;
#(
  parameter  int unsigned XLEN     = DEF_XLEN,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 regfile_o_ready,
  input  logic                 regfile_i_rd_wen,
  input  logic [AW-1:0]        regfile_i_rd_addr,
  input  logic [XLEN-1:0]      regfile_i_rd_data,
  input  logic [NUM_RD*AW-1:0] regfile_i_rs_addr,
  output logic [NUM_RD*XLEN-1:0] regfile_o_rs_data,
  output logic [NUM_RD-1:0]    regfile_o_rs_busy,
  input  logic                 regfile_i_resv_en,
  input  logic [AW-1:0]        regfile_i_resv_addr,
  output logic                 regfile_o_busy_any
);

  localparam int unsigned CW    = AW + 1;
  localparam logic [CW-1:0] FIRST = (ZERO_REG != 0) ? CW'(1) : CW'(0);
  localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic              wen_d;
  logic [AW-1:0]     waddr_d;
  logic [XLEN-1:0]   wdata_d;
  logic              run;
  logic              user_wen;
  logic              resv_ok;

  assign run = (state_q == ST_RUN);

  // Clear-engine sequencing and the shared write-port mux.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    unique case (state_q)
      ST_CLEAR: begin
        wen_d   = 1'b1;
        waddr_d = cnt_q[AW-1:0];
        wdata_d = '0;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        wen_d   = regfile_i_rd_wen && addr_is_real(32'(regfile_i_rd_addr), ZERO_REG != 0);
        waddr_d = regfile_i_rd_addr;
        wdata_d = regfile_i_rd_data;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Scoreboard next state: reserve takes priority over writeback clear.
  always_comb begin
    busy_d   = busy_q;
    user_wen = run && regfile_i_rd_wen;
    resv_ok  = run && regfile_i_resv_en
               && addr_is_real(32'(regfile_i_resv_addr), ZERO_REG != 0);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (resv_ok && (regfile_i_resv_addr == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (user_wen && (regfile_i_rd_addr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // FSM, clear counter and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= FIRST;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array, single write port; no reset so it maps to LUT RAM.
  always_ff @(posedge clk) begin
    if (!rst && wen_d) mem_q[waddr_d] <= wdata_d;
  end

  assign regfile_o_ready    = run;
  assign regfile_o_busy_any = run && (|busy_q);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    idu_regfile_sb_rdport #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rdport (
      .run      (run),
      .rs_addr  (regfile_i_rs_addr[k*AW +: AW]),
      .mem      (mem_q),
      .busy_vec (busy_q),
      .wr_en    (regfile_i_rd_wen),
      .wr_addr  (regfile_i_rd_addr),
      .wr_data  (regfile_i_rd_data),
      .rs_data  (regfile_o_rs_data[k*XLEN +: XLEN]),
      .rs_busy  (regfile_o_rs_busy[k])
    );
  end

endmodule

// File: tb/tb_idu_regfile_sb.sv
// Directed bench for idu_regfile_sb: one bypassing and one non-bypassing
// instance driven by identical stimulus.
module tb_idu_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [9:0]  rs_addr;
  logic        resv_en;
  logic [4:0]  resv_addr;

  logic        rdy_b, rdy_n;
  logic [63:0] rsd_b, rsd_n;
  logic [1:0]  rsb_b, rsb_n;
  logic        bany_b, bany_n;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  idu_regfile_sb #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .regfile_o_ready(rdy_b),
    .regfile_i_rd_wen(rd_wen), .regfile_i_rd_addr(rd_addr), .regfile_i_rd_data(rd_data),
    .regfile_i_rs_addr(rs_addr), .regfile_o_rs_data(rsd_b), .regfile_o_rs_busy(rsb_b),
    .regfile_i_resv_en(resv_en), .regfile_i_resv_addr(resv_addr),
    .regfile_o_busy_any(bany_b)
  );

  idu_regfile_sb #(.BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .regfile_o_ready(rdy_n),
    .regfile_i_rd_wen(rd_wen), .regfile_i_rd_addr(rd_addr), .regfile_i_rd_data(rd_data),
    .regfile_i_rs_addr(rs_addr), .regfile_o_rs_data(rsd_n), .regfile_o_rs_busy(rsb_n),
    .regfile_i_resv_en(resv_en), .regfile_i_resv_addr(resv_addr),
    .regfile_o_busy_any(bany_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_wen = 1'b0; rd_addr = '0; rd_data = '0;
    resv_en = 1'b0; resv_addr = '0;
  endtask

  task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1);
    rs_addr = {a1, a0};
  endtask

  initial begin
    idle();
    rs_addr = '0;
    rst = 1'b1;
    tick();
    // Reset state
    check("rst_ready_b", 64'(rdy_b), 64'd0);
    check("rst_ready_n", 64'(rdy_n), 64'd0);
    check("rst_busy_any", 64'(bany_b), 64'd0);
    check("rst_rs_busy", 64'(rsb_b), 64'd0);
    rst = 1'b0;

    // Clear sequence, with writes/reservations attempted during CLEAR
    n = 0;
    while (!rdy_b && n < 100) begin
      idle();
      if (n == 3) begin rd_wen = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEAD; end
      if (n == 5) begin
        rd_wen = 1'b1; rd_addr = 5'd2; rd_data = 32'hBEEF;
        resv_en = 1'b1; resv_addr = 5'd8;
        set_rs(5'd2, 5'd8);
        #1;
        check("clear_rs_data", rsd_b, 64'd0);
        check("clear_rs_busy", 64'(rsb_b), 64'd0);
      end
      tick();
      n++;
    end
    idle();
    check("clear_len", 64'(n), 64'd31);
    check("clear_ready_n", 64'(rdy_n), 64'd1);
    check("clear_busy_any", 64'(bany_b), 64'd0);
    for (int i = 0; i < 32; i++) begin
      set_rs(5'(i), 5'(31 - i));
      #1;
      check($sformatf("clear_read_%0d", i), rsd_b, 64'd0);
    end

    // Write / read / zero register
    rd_wen = 1'b1; rd_addr = 5'd7; rd_data = 32'h12345678; set_rs(5'd7, 5'd5);
    #1;
    check("wr7_byp_b", rsd_b[31:0], 32'h12345678);
    check("wr7_nobyp_n", rsd_n[31:0], 32'h0);
    tick(); idle();
    check("rd7_b", rsd_b[31:0], 32'h12345678);
    check("rd7_n", rsd_n[31:0], 32'h12345678);
    check("rd5_after_clear", rsd_b[63:32], 32'h0);
    rd_wen = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; set_rs(5'd0, 5'd0);
    #1;
    check("wr0_byp", rsd_b, 64'd0);
    tick(); idle();
    check("rd0_b", rsd_b, 64'd0);
    check("rd0_n", rsd_n, 64'd0);

    // Bypass
    rd_wen = 1'b1; rd_addr = 5'd9; rd_data = 32'hA5A5A5A5; set_rs(5'd9, 5'd9);
    #1;
    check("byp9_b", rsd_b, {32'hA5A5A5A5, 32'hA5A5A5A5});
    check("byp9_n_old", rsd_n, 64'd0);
    tick(); idle();
    check("rd9_n_new", rsd_n, {32'hA5A5A5A5, 32'hA5A5A5A5});

    // Scoreboard
    resv_en = 1'b1; resv_addr = 5'd3; set_rs(5'd3, 5'd9);
    #1;
    check("resv3_same_cycle_any", 64'(bany_b), 64'd0);
    tick(); idle();
    check("resv3_any_b", 64'(bany_b), 64'd1);
    check("resv3_rsbusy_b", 64'(rsb_b), 64'b01);
    check("resv3_rsbusy_n", 64'(rsb_n), 64'b01);
    rd_wen = 1'b1; rd_addr = 5'd3; rd_data = 32'h33;
    #1;
    check("wb3_rsbusy_b", 64'(rsb_b), 64'b00);
    check("wb3_rsbusy_n", 64'(rsb_n), 64'b01);
    check("wb3_any_b", 64'(bany_b), 64'd1);
    tick(); idle();
    check("wb3_after_any_b", 64'(bany_b), 64'd0);
    check("wb3_after_any_n", 64'(bany_n), 64'd0);
    check("wb3_after_rsbusy_n", 64'(rsb_n), 64'b00);

    // Simultaneous reserve / write
    resv_en = 1'b1; resv_addr = 5'd4;
    tick(); idle();
    resv_en = 1'b1; resv_addr = 5'd4; rd_wen = 1'b1; rd_addr = 5'd4; rd_data = 32'h44;
    tick(); idle();
    set_rs(5'd4, 5'd6);
    #1;
    check("same4_busy", 64'(rsb_b), 64'b01);
    check("same4_data", rsd_b[31:0], 32'h44);
    check("same4_any", 64'(bany_b), 64'd1);
    resv_en = 1'b1; resv_addr = 5'd6; rd_wen = 1'b1; rd_addr = 5'd4; rd_data = 32'h55;
    tick(); idle();
    check("diff_busy_b", 64'(rsb_b), 64'b10);
    check("diff_busy_n", 64'(rsb_n), 64'b10);
    check("diff_data4", rsd_b[31:0], 32'h55);
    rd_wen = 1'b1; rd_addr = 5'd6; rd_data = 32'h66;
    tick(); idle();
    check("drain_any", 64'(bany_b), 64'd0);

    // Reset mid-clear
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    set_rs(5'd7, 5'd9);
    #1;
    check("midclear_rs_data", rsd_b, 64'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    n = 0;
    while (!rdy_b && n < 100) begin tick(); n++; end
    check("restart_clear_len", 64'(n), 64'd31);
    check("restart_rd7", rsd_b[31:0], 32'h0);

    // Reset in RUN with x2 busy
    rd_wen = 1'b1; rd_addr = 5'd2; rd_data = 32'h22;
    tick(); idle();
    resv_en = 1'b1; resv_addr = 5'd2;
    tick(); idle();
    set_rs(5'd2, 5'd2);
    #1;
    check("run2_busy_any", 64'(bany_b), 64'd1);
    check("run2_data", rsd_b[31:0], 32'h22);
    rst = 1'b1; tick();
    check("runrst_any", 64'(bany_b), 64'd0);
    check("runrst_ready", 64'(rdy_b), 64'd0);
    rst = 1'b0;
    n = 0;
    while (!rdy_b && n < 100) begin tick(); n++; end
    check("runrst_clear_len", 64'(n), 64'd31);
    check("runrst_rd2", rsd_b, 64'd0);
    check("runrst_rsbusy", 64'(rsb_b), 64'd0);
    check("runrst_any_after", 64'(bany_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
